dm_access_ctrl: RTL

- Load/store sequencer between the CPU's MEM-stage request and the byte-wide data memory.
- The data memory reads 4 bytes combinationally, big-endian: {M[a],M[a+1],M[a+2],M[a+3]}. It writes only MemWriteData[7:0] to M[a] on each clock edge.
- This block breaks half-word and word stores into per-byte write cycles, and extracts and sign- or zero-extends byte/half loads.
- It checks alignment and range, and returns a single-cycle response to the pipeline.

---
 rtl/dm_access_ctrl.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/dm_access_ctrl.sv
// Load/store sequencer between the MEM-stage request and a byte-wide data memory.
// Splits half/word stores into big-endian byte writes and extends byte/half loads.
module dm_access_ctrl #(
    parameter int MEM_SIZE = 128
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        req_ready,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic [31:0] dm_addr,
    output logic [31:0] dm_wdata,
    output logic        dm_write,
    output logic        dm_read,
    input  logic [31:0] dm_rdata
);

    localparam logic [1:0] IDLE  = 2'b00;
    localparam logic [1:0] READ  = 2'b01;
    localparam logic [1:0] WRITE = 2'b10;
    localparam logic [1:0] RESP  = 2'b11;

    logic [1:0]  state;
    logic [1:0]  byteCnt;
    logic [31:0] addrReg;
    logic [31:0] wdataReg;
    logic [31:0] rdataReg;
    logic [1:0]  sizeReg;
    logic        unsignedReg;
    logic        errReg;

    logic [1:0]  reqLastIdx;
    logic [32:0] reqEndAddr;
    logic        reqErr;
    logic        accept;
    logic [1:0]  lastIdx;
    logic [1:0]  byteSel;
    logic        signFill;
    logic [31:0] loadData;

    assign req_ready = (state == IDLE);
    assign accept    = req_valid && req_ready;

    // Request decode; the end address is formed one bit wider so a range check near 2^32 cannot wrap.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path can infer a latch.
        reqLastIdx = 2'd0;
        case (req_size)
            2'b01:   reqLastIdx = 2'd1;
            2'b10:   reqLastIdx = 2'd3;
            default: reqLastIdx = 2'd0;
        endcase
        reqEndAddr = {1'b0, req_addr} + {31'b0, reqLastIdx};
        reqErr = (req_size == 2'b11)
              || ((req_size == 2'b01) && req_addr[0])
              || ((req_size == 2'b10) && (req_addr[1:0] != 2'b00))
              || (reqEndAddr >= 33'(MEM_SIZE));
    end

    always_comb begin
        lastIdx = 2'd0;
        case (sizeReg)
            2'b01:   lastIdx = 2'd1;
            2'b10:   lastIdx = 2'd3;
            default: lastIdx = 2'd0;
        endcase
        byteSel  = lastIdx - byteCnt;
        signFill = 1'b0;
        loadData = dm_rdata;
        case (sizeReg)
            2'b00: begin
                signFill = !unsignedReg && dm_rdata[31];
                loadData = {{24{signFill}}, dm_rdata[31:24]};
            end
            2'b01: begin
                signFill = !unsignedReg && dm_rdata[31];
                loadData = {{16{signFill}}, dm_rdata[31:16]};
            end
            default: loadData = dm_rdata;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (!rst_n) begin
            state       <= IDLE;
            byteCnt     <= 2'd0;
            addrReg     <= 32'd0;
            wdataReg    <= 32'd0;
            rdataReg    <= 32'd0;
            sizeReg     <= 2'd0;
            unsignedReg <= 1'b0;
            errReg      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        addrReg     <= req_addr;
                        wdataReg    <= req_wdata;
                        sizeReg     <= req_size;
                        unsignedReg <= req_unsigned;
                        errReg      <= reqErr;
                        rdataReg    <= 32'd0;
                        byteCnt     <= 2'd0;
                        if (reqErr)         state <= RESP;
                        else if (req_write) state <= WRITE;
                        else                state <= READ;
                    end
                end
                READ: begin
                    rdataReg <= loadData;
                    state    <= RESP;
                end
                WRITE: begin
                    if (byteCnt == lastIdx) state   <= RESP;
                    else                    byteCnt <= byteCnt + 2'd1;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Memory and response buses are pure functions of state, so they are quiet outside their phases.
    always_comb begin
        dm_read    = 1'b0;
        dm_write   = 1'b0;
        dm_addr    = 32'd0;
        dm_wdata   = 32'd0;
        resp_valid = 1'b0;
        resp_rdata = 32'd0;
        resp_err   = 1'b0;
        case (state)
            READ: begin
                dm_read = 1'b1;
                dm_addr = addrReg;
            end
            WRITE: begin
                dm_write = 1'b1;
                dm_addr  = addrReg + {30'd0, byteCnt};
                case (byteSel)
                    2'd0:    dm_wdata = {24'd0, wdataReg[7:0]};
                    2'd1:    dm_wdata = {24'd0, wdataReg[15:8]};
                    2'd2:    dm_wdata = {24'd0, wdataReg[23:16]};
                    default: dm_wdata = {24'd0, wdataReg[31:24]};
                endcase
            end
            RESP: begin
                resp_valid = 1'b1;
                resp_rdata = rdataReg;
                resp_err   = errReg;
            end
            default: ;
        endcase
    end

endmodule
